// File: rtl/debug_frame_initiator.sv
// debug_frame_initiator
// Host-side initiator for the on-chip debug frame protocol. It latches one
// request, sends it as a 12-byte frame on the TX byte stream, then hunts for
// the 5A A5 sync pair on the RX stream and checks the 8-byte acknowledge.
//
// Optional build macro: DEBUG_INITIATOR_RETRY_EN
//   defined   - a failed exchange (status 1, 2 or 3) resends the latched frame
//               up to MAX_RETRY times before reporting the last status.
//   undefined - every failure is reported immediately; no retry counter.
module debug_frame_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_payload,
    output logic        busy
);

    // Wide enough to hold TIMEOUT_CYCLES itself.
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SYNC0 = 8'h5A;
    localparam logic [7:0] SYNC1 = 8'hA5;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_CSUM    = 2'd1;
    localparam logic [1:0] ST_CMD     = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_SYNC0,
        S_WAIT_SYNC1,
        S_RECV,
        S_DONE
    } state_t;

    // Parameter guard: this block only elaborates for an unsupported
    // configuration (retry limit beyond the 4-bit counter, or a timeout too
    // short to let one byte through), making such a build easy to spot.
    generate
        if (MAX_RETRY > 15 || TIMEOUT_CYCLES < 2) begin : g_unsupported_params
        end
    endgenerate

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    sum_q, sum_d;
    logic          cmd_ok_q, cmd_ok_d;
    logic [31:0]   pay_q, pay_d;

    logic          req_ready_q, req_ready_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [1:0]    rsp_status_q, rsp_status_d;
    logic [31:0]   rsp_payload_q, rsp_payload_d;
    logic          busy_q, busy_d;

`ifdef DEBUG_INITIATOR_RETRY_EN
    logic [3:0]    retry_q, retry_d;
`endif

    // Exchange-finished signalling from the receive path to the retry/report logic.
    logic          finish;
    logic [1:0]    fin_status;
    logic [31:0]   fin_payload;

    // Checksummed body of the request: CMD, ADDR big-endian, DATA big-endian.
    logic [7:0]    body [9];
    logic [7:0]    body_sum;
    logic [7:0]    tx_csum;
    logic [7:0]    rx_sum;

    assign body[0] = cmd_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_body_fields
            assign body[1 + gi] = addr_q[31 - 8*gi -: 8];
            assign body[5 + gi] = data_q[31 - 8*gi -: 8];
        end
    endgenerate

    // Request checksum: negated mod-256 sum so CMD..CSUM add up to zero.
    always_comb begin
        body_sum = 8'h00;
        for (int i = 0; i < 9; i++) begin
            body_sum = body_sum + body[i];
        end
        tx_csum = 8'h00 - body_sum;
    end

    // Running reply sum including the byte arriving this cycle.
    assign rx_sum = sum_q + rx_byte;

    // Next-state and next-output computation for the whole exchange.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        data_d        = data_q;
        tmo_d         = tmo_q;
        sum_d         = sum_q;
        cmd_ok_d      = cmd_ok_q;
        pay_d         = pay_q;
        rsp_status_d  = rsp_status_q;
        rsp_payload_d = rsp_payload_q;
        finish        = 1'b0;
        fin_status    = ST_OK;
        fin_payload   = 32'h0;
`ifdef DEBUG_INITIATOR_RETRY_EN
        retry_d       = retry_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cmd_d   = req_cmd;
                    addr_d  = req_addr;
                    data_d  = req_data;
                    idx_d   = 4'd0;
                    state_d = S_SEND;
`ifdef DEBUG_INITIATOR_RETRY_EN
                    retry_d = 4'd0;
`endif
                end
            end

            S_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (idx_q == 4'd11) begin
                        state_d = S_WAIT_SYNC0;
                        tmo_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            S_WAIT_SYNC0, S_WAIT_SYNC1, S_RECV: begin
                // A byte arriving on the timeout cycle wins over the timeout.
                if (rx_valid) begin
                    tmo_d = '0;
                    case (state_q)
                        S_WAIT_SYNC0: begin
                            if (rx_byte == SYNC0) begin
                                state_d = S_WAIT_SYNC1;
                            end
                        end
                        S_WAIT_SYNC1: begin
                            if (rx_byte == SYNC1) begin
                                state_d = S_RECV;
                                idx_d   = 4'd0;
                                sum_d   = 8'h00;
                            end else if (rx_byte != SYNC0) begin
                                state_d = S_WAIT_SYNC0;
                            end
                        end
                        default: begin
                            sum_d = rx_sum;
                            idx_d = idx_q + 4'd1;
                            if (idx_q == 4'd0) begin
                                cmd_ok_d = (rx_byte == (cmd_q | 8'h80));
                            end else if (idx_q <= 4'd4) begin
                                pay_d = {pay_q[23:0], rx_byte};
                            end else begin
                                finish      = 1'b1;
                                fin_payload = pay_q;
                                if (rx_sum != 8'h00) begin
                                    fin_status = ST_CSUM;
                                end else if (!cmd_ok_q) begin
                                    fin_status = ST_CMD;
                                end else begin
                                    fin_status = ST_OK;
                                end
                            end
                        end
                    endcase
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    finish      = 1'b1;
                    fin_status  = ST_TIMEOUT;
                    fin_payload = 32'h0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A finished exchange either restarts the frame or gets reported.
        if (finish) begin
`ifdef DEBUG_INITIATOR_RETRY_EN
            if (fin_status != ST_OK && retry_q < 4'(MAX_RETRY)) begin
                state_d = S_SEND;
                idx_d   = 4'd0;
                retry_d = retry_q + 4'd1;
            end else
`endif
            begin
                state_d       = S_DONE;
                rsp_status_d  = fin_status;
                rsp_payload_d = fin_payload;
            end
        end

        // Outputs are registered copies of what the next state implies, so
        // tx_ready never reaches tx_valid combinationally.
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        tx_valid_d  = (state_d == S_SEND);
        rsp_valid_d = (state_d == S_DONE);
        tx_byte_d   = 8'h00;
        if (state_d == S_SEND) begin
            case (idx_d)
                4'd0:    tx_byte_d = SYNC0;
                4'd1:    tx_byte_d = SYNC1;
                4'd11:   tx_byte_d = tx_csum;
                default: tx_byte_d = body[idx_d - 4'd2];
            endcase
        end
    end

    // State, datapath and registered outputs; reset abandons any exchange.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= 4'd0;
            cmd_q         <= 8'h00;
            addr_q        <= 32'h0;
            data_q        <= 32'h0;
            tmo_q         <= '0;
            sum_q         <= 8'h00;
            cmd_ok_q      <= 1'b0;
            pay_q         <= 32'h0;
            req_ready_q   <= 1'b1;
            tx_valid_q    <= 1'b0;
            tx_byte_q     <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= 2'd0;
            rsp_payload_q <= 32'h0;
            busy_q        <= 1'b0;
`ifdef DEBUG_INITIATOR_RETRY_EN
            retry_q       <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            tmo_q         <= tmo_d;
            sum_q         <= sum_d;
            cmd_ok_q      <= cmd_ok_d;
            pay_q         <= pay_d;
            req_ready_q   <= req_ready_d;
            tx_valid_q    <= tx_valid_d;
            tx_byte_q     <= tx_byte_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_payload_q <= rsp_payload_d;
            busy_q        <= busy_d;
`ifdef DEBUG_INITIATOR_RETRY_EN
            retry_q       <= retry_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_valid    = tx_valid_q;
    assign tx_byte     = tx_byte_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_payload = rsp_payload_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_debug_frame_initiator.sv
// Directed testbench for debug_frame_initiator. Inputs are driven and outputs
// sampled on the falling clock edge; rsp_valid pulses are captured by a
// monitor shortly after each rising edge.
module tb_debug_frame_initiator;

    localparam int TMO = 100;
`ifdef DEBUG_INITIATOR_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_payload;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          rsp_count = 0;
    int          rsp_cyc = 0;
    logic [1:0]  last_status = 2'd0;
    logic [31:0] last_payload = 32'h0;

    logic [7:0]  exp_tx [12];
    logic [7:0]  seq [$];

    debug_frame_initiator #(
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .tx_valid    (tx_valid),
        .tx_byte     (tx_byte),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rsp_valid   (rsp_valid),
        .rsp_status  (rsp_status),
        .rsp_payload (rsp_payload),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rsp_valid === 1'b1) begin
            rsp_count    = rsp_count + 1;
            rsp_cyc      = cyc;
            last_status  = rsp_status;
            last_payload = rsp_payload;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic set_frame_a();
        exp_tx = '{8'h5A, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00,
                   8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC6};
    endtask

    task automatic set_frame_b();
        exp_tx = '{8'h5A, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'hFE};
    endtask

    task automatic issue_req(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        req_cmd = c; req_addr = a; req_data = d; req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL req_accept: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd = 8'h7F; req_addr = 32'hFFFF_FFFF; req_data = 32'h1234_0000;
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL busy_after_accept: busy=%b req_ready=%b required 1/0", busy, req_ready);
        end
    endtask

    task automatic collect_tx(input bit toggle);
        int idx = 0;
        int n = 0;
        bit stalled = 1'b0;
        logic [7:0] held = 8'h00;
        while (idx < 12 && n < 400) begin
            tx_ready = toggle ? ((n % 2) == 0) : 1'b1;
            if (tx_valid === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (tx_byte !== held) begin
                        errors++; $display("FAIL tx_stable: byte %0d is %h required %h", idx, tx_byte, held);
                    end
                end
                if (tx_ready) begin
                    checks++;
                    if (tx_byte !== exp_tx[idx]) begin
                        errors++; $display("FAIL tx_byte[%0d]: got %h required %h", idx, tx_byte, exp_tx[idx]);
                    end
                    idx++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; held = tx_byte;
                end
            end
            @(negedge clk); n++;
        end
        tx_ready = 1'b1;
        checks++;
        if (idx != 12) begin
            errors++; $display("FAIL tx_count: sent %0d bytes required 12", idx);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL tx_end: tx_valid=%b required 0", tx_valid);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input int idle);
        repeat (idle) @(negedge clk);
        rx_valid = 1'b1; rx_byte = b;
        @(negedge clk);
        rx_valid = 1'b0; rx_byte = 8'h00;
    endtask

    task automatic send_seq(input int idle);
        foreach (seq[i]) send_rx(seq[i], idle);
    endtask

    task automatic wait_rsp(input string name, input int base, input logic [1:0] st,
                            input logic [31:0] pay, input int limit);
        int n = 0;
        while (rsp_count == base && n < limit) begin
            @(negedge clk); n++;
        end
        checks++;
        if (rsp_count != base + 1) begin
            errors++; $display("FAIL %s_rsp_count: got %0d pulses required 1", name, rsp_count - base);
        end
        checks++;
        if (last_status !== st || last_payload !== pay) begin
            errors++; $display("FAIL %s_rsp: status=%0d payload=%h required %0d %h",
                               name, last_status, last_payload, st, pay);
        end
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL %s_done_cycle: rsp_valid=%b req_ready=%b required 1/0", name, rsp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_idle_after: rsp_valid=%b req_ready=%b busy=%b required 0/1/0",
                               name, rsp_valid, req_ready, busy);
        end
    endtask

    // Sends the request and feeds the same bad reply to every attempt.
    task automatic failing_exchange(input string name, input logic [1:0] st);
        int base;
        set_frame_a();
        issue_req(8'h01, 32'h0000_0100, 32'hDEAD_BEEF);
        base = rsp_count;
        for (int a = 0; a < ATTEMPTS; a++) begin
            collect_tx(1'b0);
            send_seq(2);
        end
        wait_rsp(name, base, st, 32'h1234_5678, 50);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || tx_valid !== 1'b0 || tx_byte !== 8'h00 || rsp_valid !== 1'b0 ||
            rsp_status !== 2'd0 || rsp_payload !== 32'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_state: rr=%b tv=%b tb=%h rv=%b st=%0d pl=%h busy=%b required 1 0 00 0 0 0 0",
                               req_ready, tx_valid, tx_byte, rsp_valid, rsp_status, rsp_payload, busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic(input bit toggle, input string name);
        int base;
        set_frame_a();
        issue_req(8'h01, 32'h0000_0100, 32'hDEAD_BEEF);
        base = rsp_count;
        collect_tx(toggle);
        seq = '{8'h5A, 8'hA5, 8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h6B};
        send_seq(2);
        wait_rsp(name, base, 2'd0, 32'h1234_5678, 50);
    endtask

    task automatic test_garbage_sync();
        int base;
        set_frame_a();
        issue_req(8'h01, 32'h0000_0100, 32'hDEAD_BEEF);
        base = rsp_count;
        collect_tx(1'b0);
        seq = '{8'h00, 8'h5A, 8'h5A, 8'hA5, 8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h6B};
        send_seq(1);
        wait_rsp("garbage", base, 2'd0, 32'h1234_5678, 50);
    endtask

    task automatic test_bad_csum();
        seq = '{8'h5A, 8'hA5, 8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h6C};
        failing_exchange("csum", 2'd1);
    endtask

    task automatic test_cmd_mismatch();
        seq = '{8'h5A, 8'hA5, 8'h82, 8'h12, 8'h34, 8'h56, 8'h78, 8'h6A};
        failing_exchange("cmd", 2'd2);
    endtask

    task automatic test_timeout();
        int base;
        int entry;
        set_frame_a();
        issue_req(8'h01, 32'h0000_0100, 32'hDEAD_BEEF);
        base = rsp_count;
        entry = 0;
        for (int a = 0; a < ATTEMPTS; a++) begin
            collect_tx(1'b0);
            entry = cyc;
        end
        wait_rsp("timeout", base, 2'd3, 32'h0, 300);
        checks++;
        if (rsp_cyc - entry != TMO) begin
            errors++; $display("FAIL timeout_latency: %0d cycles required %0d", rsp_cyc - entry, TMO);
        end
    endtask

    task automatic test_no_timeout();
        int base;
        set_frame_a();
        issue_req(8'h01, 32'h0000_0100, 32'hDEAD_BEEF);
        base = rsp_count;
        collect_tx(1'b0);
        seq = '{8'h5A, 8'hA5, 8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h6B};
        send_seq(TMO - 2);
        wait_rsp("slow_reply", base, 2'd0, 32'h1234_5678, 50);
    endtask

    task automatic test_reset_mid_frame();
        int base;
        set_frame_a();
        issue_req(8'h01, 32'h0000_0100, 32'hDEAD_BEEF);
        collect_tx(1'b0);
        base = rsp_count;
        seq = '{8'h5A, 8'hA5, 8'h81, 8'h12, 8'h34};
        send_seq(2);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_state: rr=%b busy=%b tv=%b rv=%b required 1 0 0 0",
                               req_ready, busy, tx_valid, rsp_valid);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (rsp_count != base) begin
            errors++; $display("FAIL mid_reset_no_rsp: %0d pulses required 0", rsp_count - base);
        end
        set_frame_b();
        issue_req(8'h02, 32'h0, 32'h0);
        base = rsp_count;
        collect_tx(1'b0);
        seq = '{8'h5A, 8'hA5, 8'h82, 8'h00, 8'h00, 8'h00, 8'h2A, 8'h54};
        send_seq(2);
        wait_rsp("after_reset", base, 2'd0, 32'h0000_002A, 50);
    endtask

`ifdef DEBUG_INITIATOR_RETRY_EN
    task automatic test_retry();
        int base;
        set_frame_a();
        issue_req(8'h01, 32'h0000_0100, 32'hDEAD_BEEF);
        base = rsp_count;
        collect_tx(1'b0);
        seq = '{8'h5A, 8'hA5, 8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h6C};
        send_seq(2);
        checks++;
        if (rsp_count != base) begin
            errors++; $display("FAIL retry_no_early_rsp: %0d pulses required 0", rsp_count - base);
        end
        collect_tx(1'b0);
        seq = '{8'h5A, 8'hA5, 8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h6B};
        send_seq(2);
        wait_rsp("retry_ok", base, 2'd0, 32'h1234_5678, 50);
    endtask
`endif

    initial begin
        test_reset();
        test_basic(1'b0, "basic");
        test_basic(1'b1, "backpressure");
        test_garbage_sync();
        test_bad_csum();
        test_cmd_mismatch();
        test_timeout();
        test_no_timeout();
        test_reset_mid_frame();
`ifdef DEBUG_INITIATOR_RETRY_EN
        test_retry();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
